// File: rtl/pixel_shader_out_fifo.sv
// pixel_shader_out_fifo
// Takes the free-running pixel stream from the shader CDC/invert stage, tags
// each pixel with start-of-frame / end-of-line from raster counters, buffers
// tagged pixels in a small show-ahead FIFO and presents them on a valid/ready
// stream. Pixels that arrive while the FIFO is full set a sticky overflow bit.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pixel_valid_in             input pixel strobe (no backpressure)
//   pixel_in_r/g/b             input colour channels, WIDTH bits each
//   out_valid / out_ready      output handshake
//   out_data                   head pixel {r,g,b}, r in MSBs
//   out_sof / out_eol          head pixel tags
//   fill_level                 registered entry count, 0..DEPTH
//   overflow / ovf_clear       sticky drop flag and its synchronous clear
module pixel_shader_out_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pixel_valid_in,
  input  logic [WIDTH-1:0]     pixel_in_r,
  input  logic [WIDTH-1:0]     pixel_in_g,
  input  logic [WIDTH-1:0]     pixel_in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*WIDTH-1:0]   out_data,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic [ADDR_W:0]      fill_level,
  output logic                 overflow,
  input  logic                 ovf_clear
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned PIX_W   = 3 * WIDTH;
  localparam int unsigned ENTRY_W = PIX_W + 2;
  localparam int unsigned X_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  // Storage and state
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_overflow;
  logic               r_out_valid;
  logic [ENTRY_W-1:0] r_head;

  // Next-state values
  logic [ADDR_W-1:0]  w_wr_ptr_next;
  logic [ADDR_W-1:0]  w_rd_ptr_next;
  logic [ADDR_W-1:0]  w_rd_ptr_inc;
  logic [CNT_W-1:0]   w_count_next;
  logic [X_W-1:0]     w_x_next;
  logic [Y_W-1:0]     w_y_next;
  logic               w_overflow_next;
  logic               w_out_valid_next;
  logic [ENTRY_W-1:0] w_head_next;

  // Handshake and tag decode
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_x_last;
  logic               w_y_last;
  logic               w_sof;
  logic               w_eol;
  logic [ENTRY_W-1:0] w_entry;

  // Push/pop/drop decisions; a push into a full FIFO is allowed when the head leaves this cycle
  always_comb begin
    w_full   = (r_count == CNT_W'(DEPTH));
    w_pop    = r_out_valid && out_ready;
    w_push   = pixel_valid_in && (!w_full || w_pop);
    w_drop   = pixel_valid_in && !w_push;
    w_x_last = (r_x == X_W'(H_ACTIVE - 1));
    w_y_last = (r_y == Y_W'(V_ACTIVE - 1));
    w_sof    = (r_x == '0) && (r_y == '0);
    w_eol    = w_x_last;
    w_entry  = {w_sof, w_eol, pixel_in_r, pixel_in_g, pixel_in_b};
  end

  // Raster counters track every input pixel, stored or dropped
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (pixel_valid_in) begin
      if (w_x_last) begin
        w_x_next = '0;
        w_y_next = w_y_last ? '0 : r_y + Y_W'(1);
      end else begin
        w_x_next = r_x + X_W'(1);
      end
    end
  end

  // Pointer, count and overflow update
  always_comb begin
    w_rd_ptr_inc  = r_rd_ptr + ADDR_W'(1);
    w_wr_ptr_next = w_push ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
    w_rd_ptr_next = w_pop ? w_rd_ptr_inc : r_rd_ptr;
    w_count_next  = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
    w_out_valid_next = (w_count_next != '0);
    // Set has priority over clear
    w_overflow_next = r_overflow;
    if (w_drop) begin
      w_overflow_next = 1'b1;
    end else if (ovf_clear) begin
      w_overflow_next = 1'b0;
    end
  end

  // Registered head entry: keeps outputs flopped while acting as show-ahead.
  // Zero whenever the FIFO becomes empty.
  always_comb begin
    w_head_next = r_head;
    if (w_pop) begin
      if (r_count >= CNT_W'(2)) begin
        w_head_next = r_mem[w_rd_ptr_inc];
      end else if (w_push) begin
        w_head_next = w_entry;
      end else begin
        w_head_next = '0;
      end
    end else if ((r_count == '0) && w_push) begin
      w_head_next = w_entry;
    end
  end

  // Entry storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_next;
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_overflow  <= w_overflow_next;
      r_out_valid <= w_out_valid_next;
      r_head      <= w_head_next;
    end
  end

  // Outputs come straight from registers
  assign out_valid  = r_out_valid;
  assign out_sof    = r_head[ENTRY_W-1];
  assign out_eol    = r_head[ENTRY_W-2];
  assign out_data   = r_head[PIX_W-1:0];
  assign fill_level = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_shader_out_fifo.sv
// Directed testbench for pixel_shader_out_fifo (H_ACTIVE=4, V_ACTIVE=2, DEPTH=4).
module tb_pixel_shader_out_fifo;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned H_ACTIVE = 4;
  localparam int unsigned V_ACTIVE = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 pixel_valid_in;
  logic [WIDTH-1:0]     pixel_in_r;
  logic [WIDTH-1:0]     pixel_in_g;
  logic [WIDTH-1:0]     pixel_in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [3*WIDTH-1:0]   out_data;
  logic                 out_sof;
  logic                 out_eol;
  logic [ADDR_W:0]      fill_level;
  logic                 overflow;
  logic                 ovf_clear;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pixel_shader_out_fifo #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid_in(pixel_valid_in),
    .pixel_in_r(pixel_in_r), .pixel_in_g(pixel_in_g), .pixel_in_b(pixel_in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .fill_level(fill_level),
    .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] p);
    pixel_valid_in = v;
    pixel_in_r     = p;
    pixel_in_g     = p;
    pixel_in_b     = p;
  endtask

  function automatic logic [23:0] rgb(input logic [7:0] p);
    return {p, p, p};
  endfunction

  initial begin
    logic [7:0] p;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    drive(1'b0, 8'h00);
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Streaming pass-through, one cycle latency; frame is 4x2
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = 8'h10 + 8'(i);
      drive(1'b1, p);
      tick();
      check($sformatf("seq_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("seq_data%0d", i), 32'(out_data), 32'(rgb(p)));
      check($sformatf("seq_sof%0d", i), 32'(out_sof), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("seq_eol%0d", i), 32'(out_eol), (i == 3 || i == 7) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 8'h18);
    tick();
    check("ninth_sof", 32'(out_sof), 32'd1);
    check("ninth_data", 32'(out_data), 32'h181818);
    drive(1'b0, 8'h00);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data", 32'(out_data), 32'd0);
    check("seq_ovf", 32'(overflow), 32'd0);
    tick();
    check("empty_ready_fill", 32'(fill_level), 32'd0);

    // Fill with consumer stalled, then drop two pixels (raster now x=1,y=0)
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + 8'(i));
      tick();
    end
    check("full_fill", 32'(fill_level), 32'd4);
    check("full_head", 32'(out_data), 32'hA0A0A0);
    check("full_ovf", 32'(overflow), 32'd0);
    drive(1'b1, 8'hA4);
    tick();
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_fill", 32'(fill_level), 32'd4);
    check("drop_head", 32'(out_data), 32'hA0A0A0);
    drive(1'b1, 8'hA5);
    tick();
    check("drop2_fill", 32'(fill_level), 32'd4);

    // Drain; A0..A3 sat at x=1,2,3,0 so only A2 is eol
    drive(1'b0, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_data%0d", i), 32'(out_data), 32'(rgb(8'hA0 + 8'(i))));
      check($sformatf("drain_eol%0d", i), 32'(out_eol), (i == 2) ? 32'd1 : 32'd0);
      tick();
    end
    check("drained_valid", 32'(out_valid), 32'd0);
    // Two drops advanced x to 3 on line 1
    drive(1'b1, 8'hB0);
    tick();
    check("post_drop_data", 32'(out_data), 32'hB0B0B0);
    check("post_drop_eol", 32'(out_eol), 32'd1);
    check("post_drop_sof", 32'(out_sof), 32'd0);

    // Refill to full, then clear overflow with no drop
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 8'hB0 + 8'(i));
      tick();
    end
    check("refill_fill", 32'(fill_level), 32'd4);
    check("refill_head", 32'(out_data), 32'hB0B0B0);
    drive(1'b0, 8'h00);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("clear_ovf", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop each cycle
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'hC0 + 8'(k));
      tick();
      check($sformatf("flow_fill%0d", k), 32'(fill_level), 32'd4);
      p = (k + 1 < 4) ? 8'hB0 + 8'(k + 1) : 8'hC0 + 8'(k - 3);
      check($sformatf("flow_data%0d", k), 32'(out_data), 32'(rgb(p)));
    end
    check("flow_ovf", 32'(overflow), 32'd0);

    // Drop sets overflow; drop beats a simultaneous clear
    out_ready = 1'b0;
    drive(1'b1, 8'hD0);
    tick();
    check("set_ovf", 32'(overflow), 32'd1);
    drive(1'b1, 8'hD1);
    ovf_clear = 1'b1;
    tick();
    check("set_wins_ovf", 32'(overflow), 32'd1);
    drive(1'b0, 8'h00);
    tick();
    ovf_clear = 1'b0;
    check("clear_only_ovf", 32'(overflow), 32'd0);
    check("clear_only_fill", 32'(fill_level), 32'd4);
    drive(1'b1, 8'hD2);
    tick();
    drive(1'b0, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pre_rst_fill", 32'(fill_level), 32'd3);
    check("pre_rst_ovf", 32'(overflow), 32'd1);

    // Asynchronous reset mid-line
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_fill", 32'(fill_level), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    drive(1'b1, 8'hE0);
    tick();
    drive(1'b0, 8'h00);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_sof", 32'(out_sof), 32'd1);
    check("post_rst_data", 32'(out_data), 32'hE0E0E0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
